// File: rtl/regfile_sync_bypass.sv
// rtl/regfile_sync_bypass.sv - two-read/one-write register file with sync read, write bypass and clear sequencer
// Storage array carries no reset so it stays BRAM-mappable; the clear FSM zeroes it after reset instead.
module regfile_sync_bypass #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter bit ZERO_REG       = 1'b1,
  parameter bit BYPASS         = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddrA,
  output logic [DATA_WIDTH-1:0] rdDataA,
  input  logic [ADDR_WIDTH-1:0] rdAddrB,
  output logic [DATA_WIDTH-1:0] rdDataB,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   rd_data_a_q, rd_data_a_d;
  logic [DATA_WIDTH-1:0]   rd_data_b_q, rd_data_b_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    clearing;
  logic                    running;
  logic                    we_eff;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; RUN is only left through reset
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
      state_d = ST_RUN;
    end
  end

  // FSM: outputs
  always_comb begin
    clearing = (state_q == ST_CLEAR);
    running  = (state_q == ST_RUN);
    busy     = clearing;
  end

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (clearing) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
    end
  end

  // The sequencer owns the single write port while clearing; external writes are dropped.
  always_comb begin
    we_eff    = running && write && !(ZERO_REG && wrAddr == '0);
    mem_we    = clearing || we_eff;
    mem_waddr = clearing ? clr_cnt_q : wrAddr;
    mem_wdata = clearing ? '0 : wrData;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    if (ZERO_REG && addr == '0) begin
      return '0;
    end else if (BYPASS && we_eff && wrAddr == addr) begin
      return wrData;
    end else begin
      return mem[addr];
    end
  endfunction

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (clearing) begin
      rd_data_a_d = '0;
      rd_data_b_d = '0;
    end else if (rdEn) begin
      rd_data_a_d = read_port(rdAddrA);
      rd_data_b_d = read_port(rdAddrB);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt_q   <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rdDataA = rd_data_a_q;
  assign rdDataB = rd_data_b_q;

endmodule

// File: tb/tb_regfile_sync_bypass.sv
// tb/tb_regfile_sync_bypass.sv - self-checking bench for regfile_sync_bypass (default and small no-clear/no-bypass configs)
module tb_regfile_sync_bypass;

  logic clk;
  logic reset;

  logic        a_write, a_rdEn, a_busy;
  logic [4:0]  a_wrAddr, a_rdAddrA, a_rdAddrB;
  logic [31:0] a_wrData, a_rdDataA, a_rdDataB;

  logic        b_write, b_rdEn, b_busy;
  logic [2:0]  b_wrAddr, b_rdAddrA, b_rdAddrB;
  logic [15:0] b_wrData, b_rdDataA, b_rdDataB;

  int n_checks;
  int n_errors;

  logic [31:0] ref_a [32];
  logic [15:0] ref_b [8];
  int          clear_left;
  logic [31:0] exp_a_a, exp_a_b;
  logic [15:0] exp_b_a, exp_b_b;
  logic [31:0] r;
  logic [31:0] saved;
  int          n;

  regfile_sync_bypass u_a (
    .clk(clk), .reset(reset), .write(a_write), .wrAddr(a_wrAddr), .wrData(a_wrData),
    .rdEn(a_rdEn), .rdAddrA(a_rdAddrA), .rdDataA(a_rdDataA),
    .rdAddrB(a_rdAddrB), .rdDataB(a_rdDataB), .busy(a_busy)
  );

  regfile_sync_bypass #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b0), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b0)
  ) u_b (
    .clk(clk), .reset(reset), .write(b_write), .wrAddr(b_wrAddr), .wrData(b_wrData),
    .rdEn(b_rdEn), .rdAddrA(b_rdAddrA), .rdDataA(b_rdDataA),
    .rdAddrB(b_rdAddrB), .rdDataB(b_rdDataB), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] read_a(input logic [4:0] addr, input logic we);
    if (addr == 5'd0) return 32'd0;
    if (we && a_wrAddr == addr) return a_wrData;
    return ref_a[addr];
  endfunction

  // Reference: apply the register-file rules for one rising edge using pre-edge inputs.
  task automatic model_edge();
    logic we;
    if (reset) begin
      exp_a_a = 0; exp_a_b = 0; exp_b_a = 0; exp_b_b = 0;
      clear_left = 32;
    end else begin
      if (clear_left > 0) begin
        ref_a[32 - clear_left] = 32'd0;
        clear_left--;
        exp_a_a = 0; exp_a_b = 0;
      end else begin
        we = a_write && (a_wrAddr != 5'd0);
        if (a_rdEn) begin
          exp_a_a = read_a(a_rdAddrA, we);
          exp_a_b = read_a(a_rdAddrB, we);
        end
        if (we) ref_a[a_wrAddr] = a_wrData;
      end
      if (b_rdEn) begin
        exp_b_a = ref_b[b_rdAddrA];
        exp_b_b = ref_b[b_rdAddrB];
      end
      if (b_write) ref_b[b_wrAddr] = b_wrData;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("busy_a", {31'd0, a_busy}, {31'd0, clear_left > 0});
    check_eq("rdA_a", a_rdDataA, exp_a_a);
    check_eq("rdB_a", a_rdDataB, exp_a_b);
    check_eq("busy_b", {31'd0, b_busy}, 32'd0);
    check_eq("rdA_b", {16'd0, b_rdDataA}, {16'd0, exp_b_a});
    check_eq("rdB_b", {16'd0, b_rdDataB}, {16'd0, exp_b_b});
  endtask

  task automatic idle();
    a_write = 0; a_rdEn = 0; a_wrAddr = 0; a_wrData = 0; a_rdAddrA = 0; a_rdAddrB = 0;
    b_write = 0; b_rdEn = 0; b_wrAddr = 0; b_wrData = 0; b_rdAddrA = 0; b_rdAddrB = 0;
  endtask

  task automatic a_wr(input logic [4:0] addr, input logic [31:0] data);
    a_write = 1; a_wrAddr = addr; a_wrData = data;
  endtask

  task automatic a_rd(input logic [4:0] addr_a, input logic [4:0] addr_b);
    a_rdEn = 1; a_rdAddrA = addr_a; a_rdAddrB = addr_b;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    clear_left = 32;
    exp_a_a = 0; exp_a_b = 0; exp_b_a = 0; exp_b_b = 0;
    idle();
    reset = 1;
    step();
    step();
    reset = 0;

    // Initial clear: B initialises its 8 entries, A's writes to 9 must be dropped.
    n = 0;
    while (a_busy && n < 100) begin
      idle();
      a_wr(5'd9, 32'hCAFE0000 | n); a_rd(5'(n), 5'd9);
      if (n < 8) begin b_write = 1; b_wrAddr = 3'(n); b_wrData = 16'd0; end
      step();
      n++;
    end
    check_eq("clear_cycles", n, 32);

    for (int i = 0; i < 32; i++) begin
      idle(); a_rd(5'(i), 5'(31 - i));
      step();
      check_eq("cleared_a", a_rdDataA, 32'd0);
      check_eq("cleared_b", a_rdDataB, 32'd0);
    end

    idle(); a_wr(5'd5, 32'hDEADBEEF); step();
    idle(); a_rd(5'd5, 5'd5); step();
    check_eq("t2_a", a_rdDataA, 32'hDEADBEEF);
    check_eq("t2_b", a_rdDataB, 32'hDEADBEEF);
    idle(); a_wr(5'd0, 32'h12345678); step();
    idle(); a_rd(5'd0, 5'd5); step();
    check_eq("t2_zero", a_rdDataA, 32'd0);

    idle(); a_wr(5'd7, 32'hA5A5A5A5); a_rd(5'd7, 5'd7);
    b_write = 1; b_wrAddr = 3'd7; b_wrData = 16'hA5A5; b_rdEn = 1; b_rdAddrA = 3'd7;
    step();
    check_eq("t3_bypass", a_rdDataA, 32'hA5A5A5A5);
    check_eq("t3_nobypass_old", {16'd0, b_rdDataA}, 32'd0);
    idle(); b_rdEn = 1; b_rdAddrA = 3'd7; step();
    check_eq("t3_nobypass_new", {16'd0, b_rdDataA}, 32'h0000A5A5);

    idle(); a_rd(5'd5, 5'd7); step();
    saved = a_rdDataA;
    for (int i = 0; i < 3; i++) begin
      idle(); a_wr(5'd3, 32'h11); a_rdEn = 0; a_rdAddrA = 5'(3 + i * 4); step();
      check_eq("t4_hold", a_rdDataA, saved);
    end
    idle(); a_rd(5'd3, 5'd3); step();
    check_eq("t4_read", a_rdDataA, 32'h11);

    idle(); b_write = 1; b_wrAddr = 3'd0; b_wrData = 16'hBEEF; step();
    idle(); b_rdEn = 1; b_rdAddrA = 3'd0; step();
    check_eq("t6_entry0", {16'd0, b_rdDataA}, 32'h0000BEEF);

    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      a_write = r[0]; a_rdEn = (r[2:1] != 2'b00);
      a_wrAddr = (r[7:5] == 3'd0) ? 5'd0 : 5'($urandom_range(0, 31));
      a_wrData = $urandom;
      a_rdAddrA = r[3] ? a_wrAddr : 5'($urandom_range(0, 31));
      a_rdAddrB = r[4] ? a_rdAddrA : 5'($urandom_range(0, 31));
      b_write = a_write; b_rdEn = a_rdEn; b_wrAddr = a_wrAddr[2:0]; b_wrData = a_wrData[15:0];
      b_rdAddrA = a_rdAddrA[2:0]; b_rdAddrB = a_rdAddrB[2:0];
      step();
    end

    // Asynchronous reset from RUN with non-zero outputs.
    idle(); a_wr(5'd4, 32'h55); step();
    idle(); a_rd(5'd4, 5'd4); step();
    check_eq("pre_reset", a_rdDataA, 32'h55);
    idle();
    #2 reset = 1;
    #1;
    check_eq("async_rdA", a_rdDataA, 32'd0);
    check_eq("async_busy", {31'd0, a_busy}, 32'd1);
    step();
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      idle(); a_wr(5'd12, 32'h77); a_rd(5'd12, 5'd4); step();
    end
    reset = 1;
    #1;
    check_eq("midclear_busy", {31'd0, a_busy}, 32'd1);
    step();
    reset = 0;
    n = 0;
    while (a_busy && n < 100) begin
      idle(); a_wr(5'd12, 32'h77); a_rd(5'd12, 5'd4);
      step();
      n++;
    end
    check_eq("reclear_cycles", n, 32);
    idle(); a_rd(5'd12, 5'd4); step();
    check_eq("t5_dropped", a_rdDataA, 32'd0);
    check_eq("t5_cleared", a_rdDataB, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
